// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit
// sampling. Each good frame is placed in a valid/ready holding register.
// Frame errors and overruns are reported as one-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 921600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // The mid-bit sampling scheme needs at least a few clocks per bit.
  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  logic                  rx_meta_q;
  logic                  rx_sync_q;
  logic                  rx_s;
  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  valid_q,     valid_d;
  logic                  busy_q,      busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q,   overrun_d;

  assign rx_s = rx_sync_q;

  // Next-state logic: bit timing, data capture and holding-register handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = {CNT_W{1'b0}};
          idx_d = {IDX_W{1'b0}};
          // A high line at mid-start-bit is treated as a glitch.
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = {CNT_W{1'b0}};
          idx_d          = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            state_d = ST_IDLE;
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_BREAK: begin
        // A line held low must return high before a new start bit is accepted.
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      shift_q     <= {DATA_WIDTH{1'b0}};
      data_q      <= {DATA_WIDTH{1'b0}};
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames, hand-written corner sequences and random
// traffic. All of it is checked against a transaction-level model of the
// holding register.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1600;
  localparam int BAUD      = 100;
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int HALF      = CPB / 2;
  localparam int DW        = 8;
  localparam int FRAME_CYC = CPB * (DW + 2);
  localparam int STOP_OFS  = 2 + HALF + (DW + 1) * CPB;

  logic       clk = 1'b0;
  logic       res;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  bit   rand_en  = 1'b0;
  logic ready_fixed = 1'b0;

  typedef struct {int edge_n; logic [7:0] b; logic good;} stop_t;
  typedef struct {int edge_n; logic [7:0] b;} acc_t;
  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_busy;
    logic       exp_valid_next;
  } vec_t;

  stop_t stopq[$];
  acc_t  acc_log[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       e_ferr  = 1'b0;
  logic       e_ovr   = 1'b0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .res(res), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ready: fixed value or random per cycle, changed just after the falling edge
  initial begin
    ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ready = rand_en ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Reference model: each frame is known by the edge of its stop sample.
  // At that edge a good frame loads the holding register if it is free,
  // otherwise it raises overrun. A bad stop bit raises frame_err.
  initial begin
    forever begin
      bit    acc;
      stop_t f;
      @(posedge clk);
      cyc++;
      if (res) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        stopq.delete();
      end else begin
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        acc    = m_valid && ready;
        if (acc) acc_log.push_back('{cyc, m_data});
        if (stopq.size() > 0 && stopq[0].edge_n == cyc) begin
          f = stopq.pop_front();
          if (f.good && (!m_valid || acc)) begin
            m_data  = f.b;
            m_valid = 1'b1;
          end else begin
            if (acc) m_valid = 1'b0;
            if (f.good) e_ovr = 1'b1;
            else        e_ferr = 1'b1;
          end
        end else if (acc) begin
          m_valid = 1'b0;
        end
      end
      #1;
      if (mon_en) begin
        chk("mon_valid", valid, m_valid);
        chk("mon_data", data, m_data);
        chk("mon_frame_err", frame_err, e_ferr);
        chk("mon_overrun", overrun, e_ovr);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame from a falling edge. Loop step c ends just after edge E(c)
  // of the frame.
  task automatic send_frame(input vec_t v, input bit do_chk, input int abort_c);
    logic [9:0] bits;
    bits = {v.stop, v.b, 1'b0};
    stopq.push_back('{cyc + 1 + STOP_OFS, v.b, v.stop});
    for (int c = 0; c < FRAME_CYC; c++) begin
      rx = bits[c / CPB];
      if (c == abort_c) begin
        res = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        res = 1'b0;
        rx  = 1'b1;
        return;
      end
      @(negedge clk);
      if (c == 2) chk("busy_at_e2", busy, 1'b1);
      if (do_chk && c == STOP_OFS) begin
        chk("stop_valid", valid, v.exp_valid);
        if (v.exp_valid) chk("stop_data", data, v.exp_data);
        chk("stop_frame_err", frame_err, v.exp_ferr);
        chk("stop_overrun", overrun, v.exp_ovr);
        chk("stop_busy", busy, v.exp_busy);
      end
      if (do_chk && c == STOP_OFS + 1) chk("valid_after_stop", valid, v.exp_valid_next);
    end
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   gap;

    // reset values
    res = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    res = 1'b0;
    idle(4);
    mon_en      = 1'b1;
    ready_fixed = 1'b1;
    idle(2);

    // single isolated frames with continuous accept
    vecs[0] = '{8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i], 1'b1, -1);
      idle(8);
    end

    // glitch: 4 low cycles are rejected at the start-bit sample
    for (int c = 0; c < 20; c++) begin
      rx = (c < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 1)  chk("glitch_busy_e1", busy, 1'b0);
      if (c == 9)  chk("glitch_busy_e9", busy, 1'b1);
      if (c == 10) chk("glitch_busy_e10", busy, 1'b0);
    end

    // reset in the middle of bit 3 of 0x41, then 0x42 arrives intact
    v = '{8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b0, 4 * CPB + HALF);
    idle(20);
    v = '{8'h42, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b1, -1);
    idle(8);

    // frame error followed by a held-low line, then recovery
    v = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    send_frame(v, 1'b1, -1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", busy, 1'b1);
    chk("break_valid", valid, 1'b0);
    idle(5);
    chk("break_exit_busy", busy, 1'b0);
    idle(10);
    v = '{8'h0D, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b1, -1);
    idle(8);

    // overrun: consumer stalled across two back-to-back frames
    ready_fixed = 1'b0;
    idle(4);
    v = '{8'h31, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1};
    send_frame(v, 1'b1, -1);
    v = '{8'h32, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1};
    send_frame(v, 1'b1, -1);
    ready_fixed = 1'b1;
    @(negedge clk);
    chk("ovr_release_valid", valid, 1'b0);
    idle(8);

    // back-to-back frames with continuous accept
    acc_log.delete();
    v = '{8'h0D, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b1, -1);
    v = '{8'h0A, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b1, -1);
    v = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(v, 1'b1, -1);
    idle(10);
    chk("b2b_count", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("b2b_data0", acc_log[0].b, 8'h0D);
      chk("b2b_data1", acc_log[1].b, 8'h0A);
      chk("b2b_data2", acc_log[2].b, 8'h7E);
      chk("b2b_gap01", acc_log[1].edge_n - acc_log[0].edge_n, FRAME_CYC);
      chk("b2b_gap12", acc_log[2].edge_n - acc_log[1].edge_n, FRAME_CYC);
    end

    // random traffic with random consumer stalls
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      v.b    = 8'($urandom);
      v.stop = ($urandom_range(0, 5) != 0);
      if (v.stop) gap = $urandom_range(0, 2) * CPB + $urandom_range(0, 5);
      else        gap = CPB + $urandom_range(0, 20);
      send_frame(v, 1'b0, -1);
      if (gap > 0) idle(gap);
    end
    rand_en     = 1'b0;
    ready_fixed = 1'b1;
    idle(40);
    chk("stopq_drained", stopq.size(), 0);
    chk("final_valid", valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart of the system's UART transmit path. It recovers 8N1 frames from an asynchronous `rx` line, samples each bit at mid-bit, and presents each received byte on a valid/ready holding register. It sits between the board RX pin and a command consumer, such as a debugger or control block, so the host can send ASCII commands into the SoC over the same link the ring buffer and UART transmitter use for output.

## Interface
Parameters:
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `BAUD`, default 921600: line rate.
- `DATA_WIDTH`, default 8: data bits per frame, sent LSB first.
- Derived value `CLKS_PER_BIT = CLK_FREQ / BAUD`, using integer division.
- Derived value `HALF = CLKS_PER_BIT / 2`.
- `CLKS_PER_BIT` must be at least 4. An elaboration-time assertion enforces this.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `res`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  serial line. It is asynchronous to `clk` and idles high.
- `data`  out  DATA_WIDTH  received byte. It is stable while `valid` is high.
- `valid`  out  1  a byte is held in `data`.
- `ready`  in  1  consumer accepts the byte. A transfer happens on any edge where `valid && ready`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, producing `rx_s`. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. A bit counter of width `$clog2(CLKS_PER_BIT)` and a bit index of width `$clog2(DATA_WIDTH)` drive the FSM.
- **IDLE:**
  - If `rx_s`=0, go to START and clear the counter.
- **START:**
  - The counter increments each cycle.
  - When the counter reaches HALF-1, sample `rx_s`.
  - If the sample is 1, it was a glitch: return to IDLE with no flags raised.
  - If the sample is 0, go to DATA with the counter and bit index cleared.
- **DATA:**
  - When the counter reaches CLKS_PER_BIT-1, sample `rx_s` into shift register bit [index], clear the counter and increment the index.
  - After bit DATA_WIDTH-1 is sampled, go to STOP.
- **STOP:**
  - When the counter reaches CLKS_PER_BIT-1, sample the stop bit.
  - If the stop bit is 1 and the register is free (`!valid`, or `valid && ready` on this edge), load `data` from the shift register and set `valid`=1.
  - If the stop bit is 1 and the register is full, keep the old `data` and `valid`, and pulse `overrun`.
  - If the stop bit is 1, in either case return to IDLE. Returning at mid-stop-bit allows back-to-back frames.
  - If the stop bit is 0, pulse `frame_err`, discard the byte and go to BREAK.
- **BREAK:**
  - Stay until `rx_s`=1, then go to IDLE. A held-low line never produces repeated frames.
- **Handshake:**
  - `valid` clears on the edge after `valid && ready`.
  - If an accept and a new load happen on the same edge, `valid` stays 1, `data` takes the new byte, and `overrun` does not pulse.
- **Reset:**
  - `res` high at any time, including mid-frame, forces IDLE, clears both counters and the shift register, and sets both synchronizer flops to 1.
  - Reset values: `data`=0, `valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
  - After reset deasserts, a partially received frame is not resumed. The next low seen in IDLE is treated as a start bit.

## Timing
- Let E0 be the first rising edge that samples pin `rx`=0.
- `rx_s` goes low after E1. The FSM enters START at E2.
- The start bit is sampled at E(2+HALF).
- Data bit i is sampled at E(2+HALF+(i+1)·CLKS_PER_BIT).
- The stop bit is sampled at E(2+HALF+(DATA_WIDTH+1)·CLKS_PER_BIT).
- `valid`, `frame_err` and `overrun` change only on that stop-sample edge.
- Worked example with DATA_WIDTH=8, CLKS_PER_BIT=16: `valid` is high from E154.
- `busy` is high from E2 until the edge on which the FSM returns to IDLE.
- All outputs are registered. There is no combinational path from `ready` or `rx` to any output.

## Test plan
All scenarios use CLK_FREQ=1600, BAUD=100 (CLKS_PER_BIT=16).
- **Reset values:** assert `res` for 3 cycles with `rx`=1 → `data`=0x00, and `valid`, `busy`, `frame_err`, `overrun` all 0. Assert `res` mid-frame at bit 3 of 0x41 → outputs return to reset values; a following 0x42 is received correctly.
- **Single byte:** drive 'A' (0x41) at 16 clocks per bit with `ready`=1 → `valid` high for exactly 1 cycle starting E154 with `data`=0x41; `frame_err`=`overrun`=0.
- **Glitch:** pull `rx` low for 4 cycles → `busy` is high only until the start sample at E10, then 0; no `valid`, no flags.
- **Frame error and recovery:** send 0x55 with the stop bit low, then hold `rx` low for 40 cycles → one `frame_err` pulse, no `valid`, `busy`=1 during BREAK. Release `rx`, then send 0x0D → `valid` with `data`=0x0D.
- **Overrun:** hold `ready`=0 and send 0x31 then 0x32 back-to-back → `data` stays 0x31 and `overrun` pulses once at the second stop sample. Raise `ready` → `valid` drops the next cycle.
- **Back-to-back with continuous accept:** send 0x0D, 0x0A, 0x7E with no idle gap and `ready`=1 → three `valid` pulses spaced 160 cycles apart with the correct data, and no flags.
